// File: rtl/approx_umul_pipe.sv
// Pipelined unsigned approximate multiplier with column truncation, exact/approx mode per beat.
// Define APPROX_UMUL_COMP_EN to add the 2^(TRUNC-1) mean-error bias (saturating) in approx mode.
module approx_umul_pipe #(
  parameter int WIDTH  = 8,
  parameter int TRUNC  = 8,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 approx_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   z,
  output logic                 out_approx
);

  localparam int PW   = 2 * WIDTH;
  localparam int HALF = WIDTH / 2;
  localparam int NMID = (STAGES >= 3) ? (STAGES - 2) : 0;
  localparam int CSH  = (TRUNC > 0) ? (TRUNC - 1) : 0;
  localparam logic [PW:0] BIAS = (PW + 1)'(1) << CSH;

  // Sum of rows lo..hi-1 of the partial-product array; in approx mode bits in
  // columns below TRUNC are masked off. One extra bit carries the bias/overflow.
  function automatic logic [PW:0] row_sum(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic             apx,
                                          input int               lo,
                                          input int               hi);
    logic [PW:0]      acc;
    logic [WIDTH-1:0] m;
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m = b;
      for (int j = 0; j < WIDTH; j++) begin
        if (apx && ((i + j) < TRUNC)) m[j] = 1'b0;
      end
      if ((i >= lo) && (i < hi) && a[i]) acc = acc + ((PW + 1)'(m) << i);
    end
    return acc;
  endfunction

  function automatic logic [PW-1:0] sat_prod(input logic [PW:0] s);
    return s[PW] ? {PW{1'b1}} : s[PW-1:0];
  endfunction

  logic              w_advance;
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_apx;
  logic [PW-1:0]     r_z;

  assign w_advance = ~r_vld[STAGES-1] | out_ready;
  assign in_ready  = w_advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_apx <= '0;
    end else if (w_advance) begin
      r_vld[0] <= in_valid;
      r_apx[0] <= approx_en;
      for (int k = 1; k < STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_apx[k] <= r_apx[k-1];
      end
    end
  end

  logic [WIDTH-1:0] w_xs;
  logic [WIDTH-1:0] w_ys;
  logic             w_as;

  // ---- stage 1: operand registers (folded into the output stage when STAGES=1)
  generate
    if (STAGES >= 2) begin : g_in_reg
      logic [WIDTH-1:0] r_x_p1;
      logic [WIDTH-1:0] r_y_p1;
      always_ff @(posedge clk) begin
        if (w_advance) begin
          r_x_p1 <= x;
          r_y_p1 <= y;
        end
      end
      assign w_xs = r_x_p1;
      assign w_ys = r_y_p1;
      assign w_as = r_apx[0];
    end else begin : g_in_comb
      assign w_xs = x;
      assign w_ys = y;
      assign w_as = approx_en;
    end
  endgenerate

  logic [PW:0] w_bias;
  logic [PW:0] w_lo_p1;
  logic [PW:0] w_hi_p1;

`ifdef APPROX_UMUL_COMP_EN
  assign w_bias = (w_as && (TRUNC > 0)) ? BIAS : '0;
`else
  assign w_bias = '0;
`endif

  assign w_lo_p1 = row_sum(w_xs, w_ys, w_as, 0, HALF) + w_bias;
  assign w_hi_p1 = row_sum(w_xs, w_ys, w_as, HALF, WIDTH);

  logic [PW:0] w_lo_f;
  logic [PW:0] w_hi_f;

  // ---- middle stages: low/high row-group partial sums
  generate
    if (NMID > 0) begin : g_mid
      logic [PW:0] r_lo_pm [NMID];
      logic [PW:0] r_hi_pm [NMID];
      always_ff @(posedge clk) begin
        if (w_advance) begin
          r_lo_pm[0] <= w_lo_p1;
          r_hi_pm[0] <= w_hi_p1;
          for (int k = 1; k < NMID; k++) begin
            r_lo_pm[k] <= r_lo_pm[k-1];
            r_hi_pm[k] <= r_hi_pm[k-1];
          end
        end
      end
      assign w_lo_f = r_lo_pm[NMID-1];
      assign w_hi_f = r_hi_pm[NMID-1];
    end else begin : g_nomid
      assign w_lo_f = w_lo_p1;
      assign w_hi_f = w_hi_p1;
    end
  endgenerate

  // ---- final stage: merge partial sums, saturate, register product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_z <= '0;
    end else if (w_advance) begin
      r_z <= sat_prod(w_lo_f + w_hi_f);
    end
  end

  assign z          = r_z;
  assign out_valid  = r_vld[STAGES-1];
  assign out_approx = r_apx[STAGES-1];

endmodule

// File: tb/tb_approx_umul_pipe.sv
// Directed bench for approx_umul_pipe: default 8x8/TRUNC=8/2-stage instance plus a 4x4/TRUNC=3/1-stage sweep.
module tb_approx_umul_pipe;

`ifdef APPROX_UMUL_COMP_EN
  localparam int C8 = 128;
  localparam int C4 = 4;
`else
  localparam int C8 = 0;
  localparam int C4 = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  x = '0;
  logic [7:0]  y = '0;
  logic        approx_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] z;
  logic        out_approx;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [3:0]  s_x = '0;
  logic [3:0]  s_y = '0;
  logic        s_approx_en = 1'b0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b1;
  logic [7:0]  s_z;
  logic        s_out_approx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  approx_umul_pipe #(.WIDTH(8), .TRUNC(8), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .z(z), .out_approx(out_approx)
  );

  approx_umul_pipe #(.WIDTH(4), .TRUNC(3), .STAGES(1)) u_sweep (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .x(s_x), .y(s_y), .approx_en(s_approx_en), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .z(s_z), .out_approx(s_out_approx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference for WIDTH=4, TRUNC=3: full product minus columns 0..2.
  function automatic int sweep_model(input int a, input int b, input int mode);
    int p, low, a0, a1, a2, b0, b1, b2;
    a0 = a & 1; a1 = (a >> 1) & 1; a2 = (a >> 2) & 1;
    b0 = b & 1; b1 = (b >> 1) & 1; b2 = (b >> 2) & 1;
    p = a * b;
    if (mode != 0) begin
      low = a0 * b0 + 2 * (a0 * b1 + a1 * b0) + 4 * (a0 * b2 + a1 * b1 + a2 * b0);
      p = p - low + C4;
      if (p > 255) p = 255;
    end
    return p;
  endfunction

  task automatic run_op(input logic [7:0] xa, input logic [7:0] ya, input logic a,
                        input int exp, input string tag);
    in_valid = 1'b1; x = xa; y = ya; approx_en = a; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_z"}, 32'(z), 32'(exp));
    check({tag, "_apx"}, 32'(out_approx), 32'(a));
  endtask

  logic [7:0]  bx [6] = '{8'd255, 8'd200, 8'd16, 8'd15, 8'd3, 8'd3};
  logic [7:0]  by [6] = '{8'd255, 8'd100, 8'd16, 8'd15, 8'd200, 8'd200};
  logic        ba [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int          bz [6];

  initial begin
    int sent, got;
    logic        stalled;
    logic [15:0] hold_z;

    bz[0] = 63232 + C8; bz[1] = 20000; bz[2] = 256 + C8;
    bz[3] = 0 + C8;     bz[4] = 600;   bz[5] = 256 + C8;

    // Reset state
    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_z", 32'(z), 32'd0);
    check("rst_out_approx", 32'(out_approx), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single operations, 2-cycle latency
    run_op(8'd255, 8'd255, 1'b1, 63232 + C8, "apx_255x255");
    run_op(8'd255, 8'd255, 1'b0, 65025,      "ex_255x255");
    run_op(8'd16,  8'd16,  1'b1, 256 + C8,   "apx_16x16");
    run_op(8'd15,  8'd15,  1'b1, 0 + C8,     "apx_15x15");
    run_op(8'd3,   8'd200, 1'b1, 256 + C8,   "apx_3x200");
    run_op(8'd3,   8'd200, 1'b0, 600,        "ex_3x200");
    @(posedge clk); #1;

    // Back-to-back stream with a 3-cycle output stall
    sent = 0; got = 0; stalled = 1'b0; hold_z = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      in_valid = (sent < 6);
      if (sent < 6) begin
        x = bx[sent]; y = by[sent]; approx_en = ba[sent];
      end
      out_ready = !(cyc >= 4 && cyc < 7);
      #1;
      if (stalled) begin
        check("bp_hold_z", 32'(z), 32'(hold_z));
        check("bp_hold_vld", 32'(out_valid), 32'd1);
      end
      if (out_valid && !out_ready) begin
        check("bp_in_ready", 32'(in_ready), 32'd0);
        stalled = 1'b1;
        hold_z  = z;
      end else begin
        stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp_z%0d", got), 32'(z), 32'(bz[got]));
        check($sformatf("bp_apx%0d", got), 32'(out_approx), 32'(ba[got]));
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_count", 32'(got), 32'd6);
    @(posedge clk); #1;

    // Reset with two operations in flight
    in_valid = 1'b1; x = 8'd255; y = 8'd255; approx_en = 1'b0;
    @(posedge clk); #1;
    x = 8'd16; y = 8'd16; approx_en = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rm_pre_vld", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rm_async_vld", 32'(out_valid), 32'd0);
    check("rm_async_z", 32'(z), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("rm_idle%0d", k), 32'(out_valid), 32'd0);
    end
    run_op(8'd3, 8'd200, 1'b0, 600, "rm_new");
    @(posedge clk); #1;

    // Exhaustive 4x4 sweep, 1-cycle latency, both modes
    s_in_valid = 1'b1; s_out_ready = 1'b1;
    for (int mode = 0; mode < 2; mode++) begin
      for (int v = 0; v < 256; v++) begin
        s_x = 4'(v >> 4); s_y = 4'(v & 15); s_approx_en = (mode != 0);
        @(posedge clk); #1;
        check($sformatf("sw_m%0d_%0dx%0d", mode, v >> 4, v & 15),
              {22'd0, s_out_valid, s_out_approx, s_z},
              {22'd0, 1'b1, 1'(mode), 8'(sweep_model(v >> 4, v & 15, mode))});
      end
    end
    s_in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
